mem_access_ctrl: RTL

//  Sequences data-memory accesses for the MEMORY stage: takes one load/store per instruction,

---
 rtl/mem_access_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEMORY-stage data access sequencer (request/response, store formatting, load extension, stall)
//
// Takes one load/store per instruction from the execute/memory pipe register,
// runs a single request/response transaction on the data bus, and stalls the
// pipeline until it completes. A misaligned access is reported without touching
// the bus. Every access takes at least three cycles: accept (IDLE), at least
// one REQ cycle, then one DONE cycle.
//
// Ports:
//   clk, resetn                  clock (rising edge), asynchronous active-low reset
//   req_valid/req_write          access request, 1 = store
//   req_funct3/req_addr/req_wdata RV64 width code, effective address, LSB-justified store data
//   flush                        kill the in-flight instruction
//   mem_stall                    hold upstream pipe registers
//   done                         one-cycle pulse, rdata valid
//   rdata                        extended load result (0 for stores)
//   misalign                     one-cycle pulse, address not size-aligned
//   dreq_valid/addr/size/strobe/data  bus request channel
//   dresp_addr_ok/data_ok/data   bus response channel
module mem_access_ctrl #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic                flush,
    output logic                mem_stall,
    output logic                done,
    output logic [XLEN-1:0]     rdata,
    output logic                misalign,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [2:0]          dreq_size,
    output logic [XLEN/8-1:0]   dreq_strobe,
    output logic [XLEN-1:0]     dreq_data,
    input  logic                dresp_addr_ok,
    input  logic                dresp_data_ok,
    input  logic [XLEN-1:0]     dresp_data
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                lat_write;
    logic [2:0]          lat_funct3;
    logic [ADDR_W-1:0]   lat_addr;
    logic [XLEN-1:0]     lat_wdata;
    logic                drop;
    logic [XLEN-1:0]     rdata_q;

    logic                accept;
    logic                misalign_raw;
    logic                stall_raw;

    // The address-phase acknowledge carries no information here: only
    // data_ok ends an access.
    logic                unused_addr_ok;
    assign unused_addr_ok = dresp_addr_ok;

    // Funct3 111 (and any 1xx store) has no defined width; it is run as a
    // dword and never reported as misaligned.
    function automatic logic is_undef(input logic write, input logic [2:0] f3);
        return (f3 == 3'b111) || (write && f3[2]);
    endfunction

    function automatic logic [1:0] size_of(input logic write, input logic [2:0] f3);
        if (is_undef(write, f3)) begin
            return 2'd3;
        end
        return f3[1:0];
    endfunction

    // ---------------------------------------------------------------
    // Incoming request alignment check
    // ---------------------------------------------------------------
    logic [1:0] in_size;
    logic [2:0] in_mask;
    logic       in_misaligned;

    always_comb begin
        in_size = size_of(req_write, req_funct3);
        case (in_size)
            2'd0:    in_mask = 3'b000;
            2'd1:    in_mask = 3'b001;
            2'd2:    in_mask = 3'b011;
            default: in_mask = 3'b111;
        endcase
        in_misaligned = !is_undef(req_write, req_funct3) && (|(req_addr[2:0] & in_mask));
    end

    // ---------------------------------------------------------------
    // Store formatting from the latched request
    // ---------------------------------------------------------------
    logic [1:0]        lat_size;
    logic [OFF_W-1:0]  lat_off;
    logic [OFF_W+2:0]  lat_bsh;
    logic [STRB_W-1:0] base_strb;
    logic [STRB_W-1:0] strb_sh;
    logic [XLEN-1:0]   wmask;
    logic [XLEN-1:0]   wdata_sh;

    assign lat_size = size_of(lat_write, lat_funct3);
    assign lat_off  = lat_addr[OFF_W-1:0];
    assign lat_bsh  = {lat_off, 3'b000};

    always_comb begin
        case (lat_size)
            2'd0:    base_strb = STRB_W'(1);
            2'd1:    base_strb = STRB_W'(3);
            2'd2:    base_strb = STRB_W'(15);
            default: base_strb = '1;
        endcase
        // A full-width access always enables every lane, even when an
        // undefined width arrives on an unaligned address.
        strb_sh = (lat_size == 2'd3) ? '1 : (base_strb << lat_off);
        wmask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wmask[8*i +: 8] = {8{base_strb[i]}};
        end
        // Bytes above the access size are zeroed before shifting so no
        // stray register bits reach the bus.
        wdata_sh = (lat_wdata & wmask) << lat_bsh;
    end

    // ---------------------------------------------------------------
    // Load alignment and extension
    // ---------------------------------------------------------------
    logic [XLEN-1:0] rd_sh;
    logic [XLEN-1:0] load_fmt;

    always_comb begin
        rd_sh = dresp_data >> lat_bsh;
        case (lat_funct3)
            3'b000:  load_fmt = {{(XLEN-8){rd_sh[7]}},   rd_sh[7:0]};
            3'b001:  load_fmt = {{(XLEN-16){rd_sh[15]}}, rd_sh[15:0]};
            3'b010:  load_fmt = {{(XLEN-32){rd_sh[31]}}, rd_sh[31:0]};
            3'b100:  load_fmt = {{(XLEN-8){1'b0}},       rd_sh[7:0]};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}},      rd_sh[15:0]};
            3'b110:  load_fmt = {{(XLEN-32){1'b0}},      rd_sh[31:0]};
            default: load_fmt = rd_sh;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        misalign_raw = 1'b0;
        stall_raw    = 1'b0;
        dreq_valid   = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (in_misaligned) begin
                        misalign_raw = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        stall_raw = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                // The bus transaction always runs to completion; a flush
                // only marks its result to be dropped.
                dreq_valid = 1'b1;
                stall_raw  = 1'b1;
                if (dresp_data_ok) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = !drop && !flush;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // IDLE outputs depend on live request inputs; hold them low while reset
    // is asserted so every output reads 0 during reset.
    assign mem_stall = stall_raw & resetn;
    assign misalign  = misalign_raw & resetn;

    // ---------------------------------------------------------------
    // Request latch, drop flag, load result
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_write  <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            drop       <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                lat_write  <= req_write;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                drop       <= 1'b0;
            end
            if (state == REQ && flush) begin
                drop <= 1'b1;
            end
            if (state == DONE) begin
                drop <= 1'b0;
            end
            if (state == REQ && dresp_data_ok) begin
                rdata_q <= lat_write ? '0 : load_fmt;
            end
        end
    end

    assign rdata       = rdata_q;
    assign dreq_addr   = (state == REQ) ? lat_addr : '0;
    assign dreq_size   = (state == REQ) ? {1'b0, lat_size} : 3'd0;
    assign dreq_strobe = (state == REQ && lat_write) ? strb_sh : '0;
    assign dreq_data   = (state == REQ && lat_write) ? wdata_sh : '0;

endmodule
